// File: rtl/mpu_fault_log.sv
// Captures MPU violation records into a small FIFO and exposes them through a register window.
// Optional per-record cycle stamp: define MPU_FAULT_TSTAMP_EN.
module mpu_fault_log #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mpu_irq,
  input  logic [31:0] mpu_pc,
  input  logic [21:0] mpu_addr,
  input  logic        mpu_is_write,
  input  logic        reg_valid,
  output logic        reg_ready,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic [3:0]  reg_wstrb,
  output logic [31:0] reg_rdata,
  output logic        fault_irq
);

  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] SEL_STATUS  = 3'd0;
  localparam logic [2:0] SEL_CTRL    = 3'd1;
  localparam logic [2:0] SEL_HEAD_PC = 3'd2;
  localparam logic [2:0] SEL_HEAD_AD = 3'd3;
  localparam logic [2:0] SEL_HEAD_IN = 3'd4;
  localparam logic [2:0] SEL_POP     = 3'd5;
  localparam logic [2:0] SEL_TSTAMP  = 3'd6;

  logic             mpu_irq_q;
  logic             reg_ready_q;
  logic [31:0]      reg_rdata_q;
  logic             fault_irq_q;
  logic             irq_en_q, irq_en_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [21:0] addr_mem [DEPTH];
  logic        wr_mem   [DEPTH];

  logic        empty_c, full_c;
  logic        req_c, wr_c, push_req_c, push_ok_c, pop_c, clear_c, ctrl_wr_c;
  logic [2:0]  sel_c;
  logic [31:0] rdata_c;
  logic [31:0] head_ts_c;

  // Bits of the bus that have no function in this window
  logic unused_bits;
  assign unused_bits = ^{reg_wdata[31:2], reg_addr[1:0], reg_wstrb[3:1]};

  assign empty_c    = (count_q == '0);
  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign req_c      = reg_valid & ~reg_ready_q;
  assign wr_c       = req_c & (reg_wstrb != 4'b0000);
  assign sel_c      = reg_addr[4:2];
  assign push_req_c = mpu_irq & ~mpu_irq_q;
  assign push_ok_c  = push_req_c & ~full_c;
  assign pop_c      = wr_c & (sel_c == SEL_POP) & ~empty_c;
  assign ctrl_wr_c  = wr_c & (sel_c == SEL_CTRL) & reg_wstrb[0];
  assign clear_c    = ctrl_wr_c & reg_wdata[1];

`ifdef MPU_FAULT_TSTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push_ok_c && !clear_c) ts_mem[wr_ptr_q] <= cyc_q;
  end

  assign head_ts_c = empty_c ? 32'd0 : ts_mem[rd_ptr_q];
`else
  assign head_ts_c = 32'd0;
`endif

  // FIFO bookkeeping; clear overrides any push or pop in the same cycle
  always_comb begin
    irq_en_d   = irq_en_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (ctrl_wr_c) irq_en_d = reg_wdata[0];
    if (clear_c) begin
      overflow_d = 1'b0;
      drop_d     = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push_req_c && full_c) begin
        overflow_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    rdata_c = '0;
    case (sel_c)
      SEL_STATUS: begin
        rdata_c[4:0]   = 5'(count_q);
        rdata_c[8]     = empty_c;
        rdata_c[9]     = full_c;
        rdata_c[10]    = overflow_q;
        rdata_c[23:16] = drop_q;
      end
      SEL_CTRL:    rdata_c[0]    = irq_en_q;
      SEL_HEAD_PC: rdata_c       = empty_c ? 32'd0 : pc_mem[rd_ptr_q];
      SEL_HEAD_AD: rdata_c[21:0] = empty_c ? 22'd0 : addr_mem[rd_ptr_q];
      SEL_HEAD_IN: rdata_c[0]    = empty_c ? 1'b0 : wr_mem[rd_ptr_q];
      SEL_TSTAMP:  rdata_c       = head_ts_c;
      default:     rdata_c       = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok_c && !clear_c) begin
      pc_mem[wr_ptr_q]   <= mpu_pc;
      addr_mem[wr_ptr_q] <= mpu_addr;
      wr_mem[wr_ptr_q]   <= mpu_is_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mpu_irq_q   <= 1'b0;
      reg_ready_q <= 1'b0;
      reg_rdata_q <= '0;
      fault_irq_q <= 1'b0;
      irq_en_q    <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      mpu_irq_q   <= mpu_irq;
      reg_ready_q <= req_c;
      reg_rdata_q <= req_c ? rdata_c : 32'd0;
      fault_irq_q <= irq_en_q & ~empty_c;
      irq_en_q    <= irq_en_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign reg_ready = reg_ready_q;
  assign reg_rdata = reg_rdata_q;
  assign fault_irq = fault_irq_q;

endmodule

// File: tb/tb_mpu_fault_log.sv
// Directed bench for mpu_fault_log: register window, FIFO capture, overflow, clear and reset.
module tb_mpu_fault_log;

  logic        clk;
  logic        reset;
  logic        mpu_irq;
  logic [31:0] mpu_pc;
  logic [21:0] mpu_addr;
  logic        mpu_is_write;
  logic        reg_valid;
  logic        reg_ready;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata;
  logic        fault_irq;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] A_STATUS = 5'h00;
  localparam logic [4:0] A_CTRL   = 5'h04;
  localparam logic [4:0] A_PC     = 5'h08;
  localparam logic [4:0] A_AD     = 5'h0C;
  localparam logic [4:0] A_IN     = 5'h10;
  localparam logic [4:0] A_POP    = 5'h14;
  localparam logic [4:0] A_TS     = 5'h18;
  localparam logic [4:0] A_RSVD   = 5'h1C;

  mpu_fault_log #(.DEPTH(4), .PTR_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .mpu_irq      (mpu_irq),
    .mpu_pc       (mpu_pc),
    .mpu_addr     (mpu_addr),
    .mpu_is_write (mpu_is_write),
    .reg_valid    (reg_valid),
    .reg_ready    (reg_ready),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_wstrb    (reg_wstrb),
    .reg_rdata    (reg_rdata),
    .fault_irq    (fault_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One register access; returns the data delivered with reg_ready
  task automatic xfer(input logic [4:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd);
    @(negedge clk);
    reg_valid = 1'b1; reg_addr = a; reg_wdata = wd; reg_wstrb = ws;
    @(negedge clk);
    check("ready", 32'(reg_ready), 32'd1);
    rd = reg_rdata;
    reg_valid = 1'b0; reg_wstrb = 4'h0; reg_wdata = 32'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    xfer(a, 32'd0, 4'h0, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] d;
    xfer(a, wd, ws, d);
  endtask

  task automatic fault(input logic [31:0] pc, input logic [21:0] ad, input logic w);
    @(negedge clk);
    mpu_irq = 1'b1; mpu_pc = pc; mpu_addr = ad; mpu_is_write = w;
    @(negedge clk);
    mpu_irq = 1'b0;
  endtask

  // Register write issued in the same cycle as a fault rising edge
  task automatic wr_with_fault(input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pc);
    @(negedge clk);
    reg_valid = 1'b1; reg_addr = a; reg_wdata = wd; reg_wstrb = 4'hF;
    mpu_irq = 1'b1; mpu_pc = pc; mpu_addr = 22'h0; mpu_is_write = 1'b0;
    @(negedge clk);
    check("ready_sim", 32'(reg_ready), 32'd1);
    reg_valid = 1'b0; reg_wstrb = 4'h0; mpu_irq = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mpu_irq = 1'b0; mpu_pc = '0; mpu_addr = '0; mpu_is_write = 1'b0;
    reg_valid = 1'b0; reg_addr = '0; reg_wdata = '0; reg_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(reg_ready), 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    check("rst_irq", 32'(fault_irq), 32'd0);
    reset = 1'b0;

    // T1: single capture
    rd_chk("rst_status", A_STATUS, 32'h0000_0100);
    wr(A_CTRL, 32'h1, 4'hF);
    fault(32'h0000_0104, 22'h0310, 1'b1);
    rd_chk("t1_status", A_STATUS, 32'h0000_0001);
    rd_chk("t1_pc", A_PC, 32'h104);
    rd_chk("t1_ad", A_AD, 32'h310);
    rd_chk("t1_in", A_IN, 32'h1);
    check("t1_irq", 32'(fault_irq), 32'd1);
    rd_chk("rsvd", A_RSVD, 32'd0);
`ifndef MPU_FAULT_TSTAMP_EN
    rd_chk("ts_off", A_TS, 32'd0);
`endif
    @(negedge clk);
    check("ready_lo", 32'(reg_ready), 32'd0);
    wr(A_CTRL, 32'h0, 4'h2);
    rd_chk("ctrl_strb", A_CTRL, 32'h1);
    wr(A_POP, 32'h0, 4'h8);
    rd_chk("pop_status", A_STATUS, 32'h0000_0100);
    check("pop_irq", 32'(fault_irq), 32'd0);
    rd_chk("empty_pc", A_PC, 32'd0);
    wr(A_POP, 32'h0, 4'hF);
    rd_chk("pop_empty", A_STATUS, 32'h0000_0100);

    // T2: overflow with DEPTH+2 faults
    for (int i = 0; i < 6; i++) fault(32'h1000 + 32'(i), 22'(i), 1'(i));
    rd_chk("t2_status", A_STATUS, 32'h0002_0604);
    for (int i = 0; i < 4; i++) begin
      rd_chk("t2_order", A_PC, 32'h1000 + 32'(i));
      wr(A_POP, 32'h0, 4'h1);
    end
    rd_chk("t2_drained", A_STATUS, 32'h0002_0500);
    for (int i = 0; i < 264; i++) fault(32'h2000, 22'h0, 1'b0);
    rd_chk("drop_sat", A_STATUS, 32'h00FF_0604);
    wr(A_CTRL, 32'h3, 4'h1);
    rd_chk("clr_status", A_STATUS, 32'h0000_0100);
    rd_chk("clr_ctrl", A_CTRL, 32'h1);

    // T3: pop concurrent with a push
    fault(32'h200, 22'h1, 1'b0);
    wr_with_fault(A_POP, 32'h0, 32'h300);
    rd_chk("t3_status", A_STATUS, 32'h0000_0001);
    rd_chk("t3_pc", A_PC, 32'h300);
    for (int i = 1; i < 4; i++) fault(32'h300 + 32'(i), 22'h0, 1'b0);
    rd_chk("wrap_full", A_STATUS, 32'h0000_0204);
    wr_with_fault(A_POP, 32'h0, 32'h399);
    rd_chk("full_pop", A_STATUS, 32'h0001_0403);
    for (int i = 1; i < 4; i++) begin
      rd_chk("wrap_order", A_PC, 32'h300 + 32'(i));
      wr(A_POP, 32'h0, 4'hF);
    end
    rd_chk("wrap_empty", A_STATUS, 32'h0001_0500);
    wr(A_CTRL, 32'h3, 4'hF);

    // T4: level held high counts once
    @(negedge clk);
    mpu_irq = 1'b1; mpu_pc = 32'h400;
    repeat (10) @(negedge clk);
    mpu_irq = 1'b0;
    @(negedge clk);
    mpu_irq = 1'b1; mpu_pc = 32'h404;
    @(negedge clk);
    mpu_irq = 1'b0;
    rd_chk("t4_status", A_STATUS, 32'h0000_0002);
    rd_chk("t4_pc", A_PC, 32'h400);

    // T5: clear beats a concurrent push
    wr(A_CTRL, 32'h2, 4'hF);
    rd_chk("t5_pre", A_CTRL, 32'h0);
    wr_with_fault(A_CTRL, 32'h3, 32'h500);
    rd_chk("t5_status", A_STATUS, 32'h0000_0100);
    rd_chk("t5_ctrl", A_CTRL, 32'h1);
    check("t5_irq", 32'(fault_irq), 32'd0);

    // Reset during a pending access
    fault(32'h600, 22'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1; reg_valid = 1'b1; reg_addr = A_STATUS; reg_wstrb = 4'h0;
    @(negedge clk);
    check("rst_mid_ready", 32'(reg_ready), 32'd0);
    reset = 1'b0; reg_valid = 1'b0;
    rd_chk("rst_mid_status", A_STATUS, 32'h0000_0100);
    rd_chk("rst_mid_ctrl", A_CTRL, 32'h0);
    check("rst_mid_irq", 32'(fault_irq), 32'd0);

`ifdef MPU_FAULT_TSTAMP_EN
    // T6: stamps at cycles 20 and 35 after reset release
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    fault(32'h700, 22'h0, 1'b0);
    repeat (14) @(posedge clk);
    fault(32'h704, 22'h0, 1'b0);
    rd_chk("t6_ts0", A_TS, 32'd20);
    wr(A_POP, 32'h0, 4'hF);
    rd_chk("t6_ts1", A_TS, 32'd35);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
